// File: rtl/vending_controller_p.sv
// -----------------------------------------------------------------------------
// vending_controller_p
//   Card-gated vending controller. The user enters a two-digit item code, stock
//   is checked, payment is authorised, and the dispense door handshake is run.
//   Per-item stock counters are restocked on RELOAD, and a saturating counter
//   records the number of completed sales.
//
//   Optional feature macro: VM_CARD_CANCEL_EN
//     defined   : CARD_IN low in DIGIT1/DIGIT2/VALIDATE/AUTH aborts to IDLE
//                 with no flags and no stock, COST or SALES_CNT update.
//     undefined : CARD_IN is only looked at in IDLE.
//
// Ports
//   CLK         in   1        system clock, rising edge
//   RESET       in   1        asynchronous active-high reset
//   CARD_IN     in   1        card present; starts a transaction from IDLE
//   VALID_TRAN  in   1        payment authorised
//   ITEM_CODE   in   4        keypad digit, qualified by KEY_PRESS
//   KEY_PRESS   in   1        one-cycle keypad strobe
//   DOOR_OPEN   in   1        dispense door open
//   RELOAD      in   1        restock request (honoured only from IDLE)
//   VEND        out  1        item released (OPEN and CLOSE)
//   INVALID_SEL out  1        one-cycle pulse: bad, timed-out or sold-out pick
//   FAILED_TRAN out  1        one-cycle pulse: authorisation timed out
//   COST        out  COST_W   price band of the selected item
//   SOLD_OUT    out  1        selected item had zero stock
//   SALES_CNT   out  CNT_W    completed vends, saturating at all-ones
// -----------------------------------------------------------------------------
module vending_controller_p #(
  parameter int NUM_ITEMS       = 20,
  parameter int STOCK_W         = 4,
  parameter int RELOAD_QTY      = 10,
  parameter int TIMEOUT         = 5,
  parameter int ITEMS_PER_PRICE = 4,
  parameter int COST_W          = 3,
  parameter int CNT_W           = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CARD_IN,
  input  logic              VALID_TRAN,
  input  logic [3:0]        ITEM_CODE,
  input  logic              KEY_PRESS,
  input  logic              DOOR_OPEN,
  input  logic              RELOAD,
  output logic              VEND,
  output logic              INVALID_SEL,
  output logic              FAILED_TRAN,
  output logic [COST_W-1:0] COST,
  output logic              SOLD_OUT,
  output logic [CNT_W-1:0]  SALES_CNT
);

  localparam int                IDX_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam logic [3:0]        TENS_MAX = 4'((NUM_ITEMS - 1) / 10);
  localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [COST_W-1:0] COST_MAX = {COST_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RELOAD   = 4'd1,
    S_DIGIT1   = 4'd2,
    S_DIGIT2   = 4'd3,
    S_VALIDATE = 4'd4,
    S_AUTH     = 4'd5,
    S_OPEN     = 4'd6,
    S_CLOSE    = 4'd7,
    S_INVALID  = 4'd8,
    S_FAIL     = 4'd9
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         timer_q, timer_d;
  logic [3:0]         tens_q, tens_d;
  logic [IDX_W-1:0]   item_q, item_d;
  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];

  logic               vend_q, vend_d;
  logic               invalid_q, invalid_d;
  logic               failed_q, failed_d;
  logic [COST_W-1:0]  cost_q, cost_d;
  logic               sold_out_q, sold_out_d;
  logic [CNT_W-1:0]   sales_q, sales_d;

  logic               cancel;
  logic               expired;
  logic [6:0]         code_sum;
  logic               vend_start;
  logic [STOCK_W-1:0] stock_sel;
  int                 cost_band;

`ifdef VM_CARD_CANCEL_EN
  assign cancel = ~CARD_IN;
`else
  assign cancel = 1'b0;
`endif

  // Timer holds the number of cycles already spent in the current state, so
  // the TIMEOUT-th cycle is the one where it reads TIMEOUT-1.
  assign expired    = (timer_q == TMO_LAST);
  assign code_sum   = 7'(tens_q) * 7'd10 + 7'(ITEM_CODE);
  assign stock_sel  = stock_q[item_q];
  assign vend_start = (state_q == S_AUTH) && (state_d == S_OPEN);

  // State register and transaction context
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      timer_q <= 8'd0;
      tens_q  <= 4'd0;
      item_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tens_q  <= tens_d;
      item_q  <= item_d;
    end
  end

  // Next-state logic; a sampled event always beats an expiring timer
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    item_d  = item_q;
    case (state_q)
      S_IDLE: begin
        if (RELOAD)       state_d = S_RELOAD;
        else if (CARD_IN) state_d = S_DIGIT1;
        else              state_d = S_IDLE;
      end
      S_RELOAD: begin
        if (!RELOAD) state_d = S_IDLE;
        else         state_d = S_RELOAD;
      end
      S_DIGIT1: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (KEY_PRESS) begin
          if (ITEM_CODE <= TENS_MAX) begin
            tens_d  = ITEM_CODE;
            state_d = S_DIGIT2;
          end else begin
            state_d = S_INVALID;
          end
        end else if (expired) begin
          state_d = S_INVALID;
        end else begin
          state_d = S_DIGIT1;
        end
      end
      S_DIGIT2: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (KEY_PRESS) begin
          if ((ITEM_CODE <= 4'd9) && (code_sum < 7'(NUM_ITEMS))) begin
            item_d  = IDX_W'(code_sum);
            state_d = S_VALIDATE;
          end else begin
            state_d = S_INVALID;
          end
        end else if (expired) begin
          state_d = S_INVALID;
        end else begin
          state_d = S_DIGIT2;
        end
      end
      S_VALIDATE: begin
        if (cancel)                        state_d = S_IDLE;
        else if (stock_sel == STOCK_W'(0)) state_d = S_INVALID;
        else                               state_d = S_AUTH;
      end
      S_AUTH: begin
        if (cancel)          state_d = S_IDLE;
        else if (VALID_TRAN) state_d = S_OPEN;
        else if (expired)    state_d = S_FAIL;
        else                 state_d = S_AUTH;
      end
      S_OPEN: begin
        if (DOOR_OPEN)    state_d = S_CLOSE;
        else if (expired) state_d = S_IDLE;
        else              state_d = S_OPEN;
      end
      S_CLOSE: begin
        if (!DOOR_OPEN) state_d = S_IDLE;
        else            state_d = S_CLOSE;
      end
      S_INVALID: state_d = S_IDLE;
      S_FAIL:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // Any state change restarts the timer; only the timed states look at it.
    if (state_d == state_q) timer_d = timer_q + 8'd1;
    else                    timer_d = 8'd0;
  end

  // Output logic: registered outputs are computed from the upcoming state so
  // they line up with the state they describe.
  always_comb begin
    cost_band = int'(item_q) / ITEMS_PER_PRICE + 1;
    if (cost_band > int'(COST_MAX)) cost_band = int'(COST_MAX);

    vend_d     = (state_d == S_OPEN) || (state_d == S_CLOSE);
    invalid_d  = (state_d == S_INVALID);
    failed_d   = (state_d == S_FAIL);
    sold_out_d = (state_q == S_VALIDATE) && (state_d == S_INVALID);

    if (state_d == S_IDLE || state_d == S_RELOAD) cost_d = '0;
    else if (state_q != S_AUTH && state_d == S_AUTH) cost_d = COST_W'(cost_band);
    else cost_d = cost_q;

    if (vend_start && (sales_q != CNT_MAX)) sales_d = sales_q + CNT_W'(1);
    else                                    sales_d = sales_q;
  end

  // Output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vend_q     <= 1'b0;
      invalid_q  <= 1'b0;
      failed_q   <= 1'b0;
      cost_q     <= '0;
      sold_out_q <= 1'b0;
      sales_q    <= '0;
    end else begin
      vend_q     <= vend_d;
      invalid_q  <= invalid_d;
      failed_q   <= failed_d;
      cost_q     <= cost_d;
      sold_out_q <= sold_out_d;
      sales_q    <= sales_d;
    end
  end

  // Stock array: bulk restock while in RELOAD, single decrement on payment
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= '0;
    end else if (state_q == S_RELOAD) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(RELOAD_QTY);
    end else if (vend_start) begin
      stock_q[item_q] <= stock_q[item_q] - STOCK_W'(1);
    end
  end

  assign VEND        = vend_q;
  assign INVALID_SEL = invalid_q;
  assign FAILED_TRAN = failed_q;
  assign COST        = cost_q;
  assign SOLD_OUT    = sold_out_q;
  assign SALES_CNT   = sales_q;

endmodule

// File: tb/tb_vending_controller_p.sv
// Self-checking bench for vending_controller_p. Each transaction is described
// by its user-level choices (digits, delays, whether payment arrives) and the
// expected outputs follow from the selection/stock/price rules directly.
module tb_vending_controller_p;

  localparam int NUM_ITEMS = 20;
  localparam int STOCK_W   = 4;
  localparam int RELOAD_Q  = 10;
  localparam int TIMEOUT   = 5;
  localparam int IPP       = 4;
  localparam int COST_W    = 3;
  localparam int CNT_W     = 16;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              CARD_IN, VALID_TRAN, KEY_PRESS, DOOR_OPEN, RELOAD;
  logic [3:0]        ITEM_CODE;
  logic              VEND, INVALID_SEL, FAILED_TRAN, SOLD_OUT;
  logic [COST_W-1:0] COST;
  logic [CNT_W-1:0]  SALES_CNT;

  int n_cmp = 0;
  int n_err = 0;
  int stock_m [NUM_ITEMS];
  int sales_m = 0;

  vending_controller_p #(
    .NUM_ITEMS(NUM_ITEMS), .STOCK_W(STOCK_W), .RELOAD_QTY(RELOAD_Q),
    .TIMEOUT(TIMEOUT), .ITEMS_PER_PRICE(IPP), .COST_W(COST_W), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CARD_IN(CARD_IN), .VALID_TRAN(VALID_TRAN),
    .ITEM_CODE(ITEM_CODE), .KEY_PRESS(KEY_PRESS), .DOOR_OPEN(DOOR_OPEN),
    .RELOAD(RELOAD), .VEND(VEND), .INVALID_SEL(INVALID_SEL),
    .FAILED_TRAN(FAILED_TRAN), .COST(COST), .SOLD_OUT(SOLD_OUT),
    .SALES_CNT(SALES_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input int vend, input int inv,
                             input int fail, input int cost, input int sold);
    check_eq({tag, "_vend"}, int'(VEND), vend);
    check_eq({tag, "_invalid"}, int'(INVALID_SEL), inv);
    check_eq({tag, "_failed"}, int'(FAILED_TRAN), fail);
    check_eq({tag, "_cost"}, int'(COST), cost);
    check_eq({tag, "_soldout"}, int'(SOLD_OUT), sold);
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_sales"}, int'(SALES_CNT), sales_m);
    for (int i = 0; i < NUM_ITEMS; i++)
      check_eq({tag, "_stock"}, int'(dut.stock_q[i]), stock_m[i]);
  endtask

  // Inputs change at the falling edge; outputs are looked at there as well.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic zero_model();
    for (int i = 0; i < NUM_ITEMS; i++) stock_m[i] = 0;
    sales_m = 0;
  endtask

  // One-cycle INVALID/FAIL state, then back to IDLE with everything cleared.
  task automatic leave_to_idle(input string tag);
    CARD_IN = 1'b0;
    tick();
    expect_outs(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reload(input int n, input bit card);
    RELOAD  = 1'b1;
    CARD_IN = card;
    for (int i = 0; i < n; i++) begin
      tick();
      expect_outs("reload", 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < NUM_ITEMS; i++) stock_m[i] = RELOAD_Q;
    RELOAD  = 1'b0;
    CARD_IN = 1'b0;
    tick();
    expect_outs("reload_end", 0, 0, 0, 0, 0);
    check_model("reload");
  endtask

  task automatic txn(input int tens, input int units, input int d1, input int d2,
                     input int ad, input bit auth, input int dd, input int hold,
                     input bit drop);
    int item;
    int cost;
    CARD_IN = 1'b1;
    tick();
    expect_outs("dig1", 0, 0, 0, 0, 0);
    for (int i = 1; i <= d1; i++) begin
      ITEM_CODE = 4'($urandom_range(0, 15));
      tick();
      if (i < TIMEOUT) expect_outs("dig1_wait", 0, 0, 0, 0, 0);
    end
    if (d1 >= TIMEOUT) begin
      expect_outs("dig1_tmo", 0, 1, 0, 0, 0);
      leave_to_idle("dig1_tmo_idle");
      return;
    end
    KEY_PRESS = 1'b1; ITEM_CODE = 4'(tens);
    tick();
    KEY_PRESS = 1'b0;
    if (tens > (NUM_ITEMS - 1) / 10) begin
      expect_outs("bad_tens", 0, 1, 0, 0, 0);
      leave_to_idle("bad_tens_idle");
      return;
    end
    expect_outs("dig2", 0, 0, 0, 0, 0);
    for (int i = 1; i <= d2; i++) begin
      ITEM_CODE = 4'($urandom_range(0, 15));
      tick();
      if (i < TIMEOUT) expect_outs("dig2_wait", 0, 0, 0, 0, 0);
    end
    if (d2 >= TIMEOUT) begin
      expect_outs("dig2_tmo", 0, 1, 0, 0, 0);
      leave_to_idle("dig2_tmo_idle");
      return;
    end
    KEY_PRESS = 1'b1; ITEM_CODE = 4'(units);
    tick();
    KEY_PRESS = 1'b0;
    item = tens * 10 + units;
    if (units > 9 || item >= NUM_ITEMS) begin
      expect_outs("bad_item", 0, 1, 0, 0, 0);
      leave_to_idle("bad_item_idle");
      return;
    end
    expect_outs("validate", 0, 0, 0, 0, 0);
    tick();
    if (stock_m[item] == 0) begin
      expect_outs("soldout", 0, 1, 0, 0, 1);
      leave_to_idle("soldout_idle");
      return;
    end
    cost = item / IPP + 1;
    if (cost > (1 << COST_W) - 1) cost = (1 << COST_W) - 1;
    expect_outs("auth", 0, 0, 0, cost, 0);
    if (drop) CARD_IN = 1'b0;
`ifdef VM_CARD_CANCEL_EN
    if (drop) begin
      tick();
      expect_outs("cancel", 0, 0, 0, 0, 0);
      return;
    end
`endif
    if (!auth) begin
      for (int i = 1; i <= TIMEOUT; i++) begin
        RELOAD = 1'($urandom_range(0, 1));
        tick();
        if (i < TIMEOUT) expect_outs("auth_wait", 0, 0, 0, cost, 0);
      end
      RELOAD = 1'b0;
      expect_outs("auth_tmo", 0, 0, 1, cost, 0);
      leave_to_idle("fail_idle");
      return;
    end
    for (int i = 1; i <= ad; i++) begin
      RELOAD = 1'($urandom_range(0, 1));
      tick();
      expect_outs("auth_wait", 0, 0, 0, cost, 0);
    end
    RELOAD = 1'b0;
    VALID_TRAN = 1'b1;
    tick();
    VALID_TRAN = 1'b0;
    CARD_IN = 1'b0;
    stock_m[item] = stock_m[item] - 1;
    if (sales_m < (1 << CNT_W) - 1) sales_m = sales_m + 1;
    expect_outs("open", 1, 0, 0, cost, 0);
    for (int i = 1; i <= dd; i++) begin
      tick();
      if (i < TIMEOUT) expect_outs("open_wait", 1, 0, 0, cost, 0);
    end
    if (dd >= TIMEOUT) begin
      expect_outs("open_tmo", 0, 0, 0, 0, 0);
      return;
    end
    DOOR_OPEN = 1'b1;
    tick();
    expect_outs("close", 1, 0, 0, cost, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      expect_outs("close_hold", 1, 0, 0, cost, 0);
    end
    DOOR_OPEN = 1'b0;
    tick();
    expect_outs("done", 0, 0, 0, 0, 0);
  endtask

  initial begin
    RESET = 1'b1; CARD_IN = 1'b0; VALID_TRAN = 1'b0; KEY_PRESS = 1'b0;
    DOOR_OPEN = 1'b0; RELOAD = 1'b0; ITEM_CODE = 4'd0;
    zero_model();
    @(negedge CLK);
    @(negedge CLK);
    expect_outs("reset", 0, 0, 0, 0, 0);
    check_model("reset");
    RESET = 1'b0;
    tick();

    // Empty machine: item 03 is sold out
    txn(0, 3, 0, 0, 0, 1'b1, 0, 0, 1'b0);
    check_model("t2");

    // Restock, then buy item 18 (price band 5)
    do_reload(3, 1'b0);
    txn(1, 8, 0, 0, 0, 1'b1, 0, 1, 1'b0);
    check_eq("t1_stock18", int'(dut.stock_q[18]), 9);
    check_model("t1");

    // First digit out of range, then the highest legal code
    txn(2, 0, 0, 0, 0, 1'b1, 0, 0, 1'b0);
    txn(1, 9, 1, 2, 1, 1'b1, 2, 0, 1'b0);
    check_model("t3");

    // Authorisation timeout, then payment on the last allowed cycle
    txn(0, 5, 0, 0, 0, 1'b0, 0, 0, 1'b0);
    txn(0, 6, 0, 0, TIMEOUT - 1, 1'b1, TIMEOUT - 1, 0, 1'b0);
    check_model("t4");

    // Digit timeouts, door timeout, long door hold, RELOAD racing CARD_IN
    txn(1, 0, TIMEOUT, 0, 0, 1'b1, 0, 0, 1'b0);
    txn(1, 0, TIMEOUT - 1, TIMEOUT, 0, 1'b1, 0, 0, 1'b0);
    txn(0, 7, 0, 0, 0, 1'b1, TIMEOUT, 0, 1'b0);
    txn(1, 2, 0, TIMEOUT - 1, 0, 1'b1, 0, 8, 1'b0);
    do_reload(1, 1'b1);
    check_model("edges");

    // Card pulled while waiting for payment
    txn(0, 8, 0, 0, 1, 1'b1, 0, 0, 1'b1);
    check_model("t6");

    // Reset landing between edges while the door is open
    CARD_IN = 1'b1; tick();
    KEY_PRESS = 1'b1; ITEM_CODE = 4'd1; tick();
    ITEM_CODE = 4'd4; tick();
    KEY_PRESS = 1'b0; tick();
    tick();
    VALID_TRAN = 1'b1; tick();
    VALID_TRAN = 1'b0; CARD_IN = 1'b0;
    expect_outs("t5_open", 1, 0, 0, 4, 0);
    #2 RESET = 1'b1;
    #1;
    zero_model();
    expect_outs("t5_reset", 0, 0, 0, 0, 0);
    check_model("t5");
    @(negedge CLK);
    RESET = 1'b0;
    tick();
    expect_outs("t5_idle", 0, 0, 0, 0, 0);

    // Randomised transactions with occasional restocking
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) do_reload($urandom_range(1, 3), 1'($urandom_range(0, 1)));
      txn($urandom_range(0, 2), $urandom_range(0, 11),
          ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1),
          ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1),
          $urandom_range(0, TIMEOUT - 1), 1'($urandom_range(0, 4) != 0),
          ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1),
          $urandom_range(0, 7), 1'($urandom_range(0, 7) == 0));
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
